// File: rtl/alu_cmd_sequencer.sv
// Command sequencer in front of the 4-bit registered ALU: issues one op, captures its result.
// Latency: result valid three edges after acceptance, counting the accepting edge.
// Backpressure: one op in flight; cmd_ready stays low until the result is taken via res_ready.
module alu_cmd_sequencer #(
    parameter logic [4:0] ERR_VALUE = 5'h1F,
    parameter int         CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_a,
    input  logic [3:0]       cmd_b,
    input  logic [3:0]       cmd_c,
    input  logic [2:0]       cmd_sel,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [3:0]       alu_c,
    output logic [2:0]       alu_sel,
    input  logic [4:0]       alu_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [4:0]       res_data,
    output logic             res_err,
    output logic [CNT_W-1:0] op_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] c;
        logic [2:0] sel;
    } cmd_t;

    localparam logic [2:0]       OP_DIV  = 3'b011;
    localparam logic [2:0]       OP_MOD  = 3'b100;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t state, state_nxt;
    cmd_t   cmd_q;
    logic   div0;
    logic   accept;
    logic   handoff;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cmd_q    <= '0;
            div0     <= 1'b0;
            res_data <= '0;
            res_err  <= 1'b0;
            op_cnt   <= '0;
            err_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cmd_q <= '{a: cmd_a, b: cmd_b, c: cmd_c, sel: cmd_sel};
            end
            // Screen from the held operands so a changing cmd_b cannot affect it.
            if (state == ISSUE) begin
                div0 <= ((cmd_q.sel == OP_DIV) || (cmd_q.sel == OP_MOD)) && (cmd_q.b == 4'd0);
            end
            if (state == CAPTURE) begin
                res_data <= div0 ? ERR_VALUE : alu_result;
                res_err  <= div0;
            end
            if (handoff) begin
                op_cnt <= op_cnt + CNT_ONE;
                if (res_err) begin
                    err_cnt <= err_cnt + CNT_ONE;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        res_valid = 1'b0;
        accept    = 1'b0;
        handoff   = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE:   state_nxt = CAPTURE;
            CAPTURE: state_nxt = DONE;
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    handoff   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign alu_a   = cmd_q.a;
    assign alu_b   = cmd_q.b;
    assign alu_c   = cmd_q.c;
    assign alu_sel = cmd_q.sel;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: registered-ALU model, transaction-level scoreboard, directed tests.
module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_a = '0, cmd_b = '0, cmd_c = '0;
    logic [2:0] cmd_sel = '0;
    logic [3:0] alu_a, alu_b, alu_c;
    logic [2:0] alu_sel;
    logic [4:0] alu_result = '0;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [4:0] res_data;
    logic       res_err;
    logic [7:0] op_cnt, err_cnt;

    always #5 clk = ~clk;

    alu_cmd_sequencer dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_c(cmd_c), .cmd_sel(cmd_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_sel(alu_sel),
        .alu_result(alu_result),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_err(res_err),
        .op_cnt(op_cnt), .err_cnt(err_cnt)
    );

    // ALU function; divide/modulo by zero returns junk that the sequencer must replace.
    function automatic logic [4:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                          input logic [3:0] c, input logic [2:0] sel);
        logic [3:0] m;
        logic [4:0] r;
        r = 5'd0;
        case (sel)
            3'd0: begin m = (a > b) ? a : b; m = (c > m) ? c : m; r = {1'b0, m}; end
            3'd1: r = {1'b0, a} + {1'b0, b};
            3'd2: r = {1'b0, a} - {1'b0, b};
            3'd3: r = (b == 4'd0) ? 5'h0A : {1'b0, a / b};
            3'd4: r = (b == 4'd0) ? 5'h0A : {1'b0, a % b};
            3'd5: r = {1'b0, a} << b;
            3'd6: r = {1'b0, a >> b};
            default: r = {4'd0, a > b};
        endcase
        return r;
    endfunction

    always @(posedge clk) alu_result <= alu_fn(alu_a, alu_b, alu_c, alu_sel);

    int tests = 0;
    int fails = 0;

    // Transaction-level model state
    bit         pending = 0;
    int         age = 0;
    logic [4:0] q_data[$];
    bit         q_err[$];
    logic [4:0] hist[$];
    int         m_op = 0, m_err = 0;
    logic [14:0] m_alu = '0;
    int         cyc = 0, acc_cyc = 0, nhand = 0;
    bit         acc_evt = 0, hand_evt = 0;
    logic [4:0] last_data = '0;
    bit         last_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: check outputs mid-cycle, advance the model over the coming edge, return #1 after it.
    task automatic step();
        bit do_acc, do_hand;
        @(negedge clk);
        cyc++;
        if (pending && age < 3) age++;
        chk("cmd_ready", int'(cmd_ready), int'(!pending));
        chk("res_valid", int'(res_valid), int'(pending && age >= 3));
        if (pending && age >= 3 && q_data.size() > 0) begin
            chk("res_data", int'(res_data), int'(q_data[0]));
            chk("res_err", int'(res_err), int'(q_err[0]));
        end
        chk("op_cnt", int'(op_cnt), m_op);
        chk("err_cnt", int'(err_cnt), m_err);
        chk("alu_ops", int'({alu_a, alu_b, alu_c, alu_sel}), int'(m_alu));
        acc_evt  = 0;
        hand_evt = 0;
        if (rst) begin
            pending = 0; age = 0; m_op = 0; m_err = 0; m_alu = '0;
            q_data.delete(); q_err.delete();
        end else begin
            do_hand = pending && age >= 3 && res_ready;
            do_acc  = !pending && cmd_valid;
            if (do_hand) begin
                last_data = q_data.pop_front();
                last_err  = q_err.pop_front();
                hist.push_back(last_data);
                m_op = (m_op + 1) % 256;
                if (last_err) m_err = (m_err + 1) % 256;
                pending = 0; hand_evt = 1; nhand++;
            end
            if (do_acc) begin
                if ((cmd_sel == 3'd3 || cmd_sel == 3'd4) && cmd_b == 4'd0) begin
                    q_data.push_back(5'h1F); q_err.push_back(1'b1);
                end else begin
                    q_data.push_back(alu_fn(cmd_a, cmd_b, cmd_c, cmd_sel)); q_err.push_back(1'b0);
                end
                m_alu = {cmd_a, cmd_b, cmd_c, cmd_sel};
                pending = 1; age = 0; acc_evt = 1; acc_cyc = cyc;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input logic [2:0] sel);
        cmd_a = a; cmd_b = b; cmd_c = c; cmd_sel = sel; cmd_valid = 1'b1;
    endtask

    task automatic wait_accept();
        int n = 0;
        do begin step(); n++; end while (!acc_evt && n < 20);
        chk("accept_seen", int'(acc_evt), 1);
    endtask

    task automatic wait_handoff(output int n);
        n = 0;
        do begin step(); n++; end while (!hand_evt && n < 30);
        chk("handoff_seen", int'(hand_evt), 1);
    endtask

    task automatic send(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [2:0] sel, output int lat);
        set_cmd(a, b, c, sel);
        wait_accept();
        cmd_valid = 1'b0;
        wait_handoff(lat);
    endtask

    initial begin
        int lat, a1, n, h0;
        logic [3:0] ta, tb;
        logic [2:0] ts;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        step();
        rst = 1'b0;
        chk("rst_res_data", int'(res_data), 0);
        chk("rst_res_err", int'(res_err), 0);
        chk("rst_cmd_ready", int'(cmd_ready), 1);

        // max(3,9,5); accept edge plus two more edges before the handoff cycle
        res_ready = 1'b1;
        send(4'd3, 4'd9, 4'd5, 3'd0, lat);
        chk("max_data", int'(last_data), 9);
        chk("max_err", int'(last_err), 0);
        chk("latency", lat, 3);
        chk("op_cnt_1", int'(op_cnt), 1);

        // back-to-back add then sub, second command held on the bus
        set_cmd(4'd15, 4'd15, 4'd0, 3'd1);
        wait_accept();
        a1 = acc_cyc;
        set_cmd(4'd2, 4'd5, 4'd0, 3'd2);
        wait_accept();
        chk("spacing", acc_cyc - a1, 4);
        cmd_valid = 1'b0;
        wait_handoff(lat);
        chk("add_data", int'(hist[hist.size()-2]), 30);
        chk("sub_data", int'(last_data), 29);

        // divide by zero, then a legal modulo
        send(4'd7, 4'd0, 4'd0, 3'd3, lat);
        chk("div0_data", int'(last_data), 31);
        chk("div0_err", int'(last_err), 1);
        chk("err_cnt_1", int'(err_cnt), 1);
        send(4'd7, 4'd3, 4'd0, 3'd4, lat);
        chk("mod_data", int'(last_data), 1);
        chk("mod_err", int'(last_err), 0);
        chk("err_cnt_still_1", int'(err_cnt), 1);

        // downstream stall with the next command waiting
        res_ready = 1'b0;
        set_cmd(4'd4, 4'd1, 4'd0, 3'd5);
        wait_accept();
        cmd_valid = 1'b0;
        n = 0;
        do begin step(); n++; end while (!res_valid && n < 10);
        set_cmd(4'd9, 4'd2, 4'd0, 3'd6);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_valid", int'(res_valid), 1);
            chk("stall_data", int'(res_data), 8);
            chk("stall_err", int'(res_err), 0);
            chk("stall_cmd_ready", int'(cmd_ready), 0);
        end
        res_ready = 1'b1;
        wait_handoff(lat);
        chk("stall_handoff_data", int'(last_data), 8);
        step();
        chk("accept_after_handoff", int'(acc_evt), 1);
        cmd_valid = 1'b0;
        wait_handoff(lat);
        chk("shr_data", int'(last_data), 2);

        // reset while in CAPTURE
        set_cmd(4'd1, 4'd2, 4'd3, 3'd7);
        wait_accept();
        cmd_valid = 1'b0;
        step();
        h0 = nhand;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_res_valid", int'(res_valid), 0);
        chk("abort_cmd_ready", int'(cmd_ready), 1);
        chk("abort_op_cnt", int'(op_cnt), 0);
        chk("abort_res_data", int'(res_data), 0);
        chk("abort_alu_a", int'(alu_a), 0);
        repeat (4) step();
        chk("abort_no_result", nhand - h0, 0);

        // counter wrap: 257 commands, every 8th divides by zero
        for (int i = 0; i < 257; i++) begin
            ta = 4'(i);
            if (i % 8 == 7) begin
                tb = 4'd0; ts = 3'd3;
            end else begin
                tb = 4'((i % 5) + 1); ts = 3'(i % 7);
            end
            send(ta, tb, 4'd1, ts, lat);
        end
        chk("wrap_op_cnt", int'(op_cnt), 1);
        chk("wrap_err_cnt", int'(err_cnt), 32);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
